gcd_sweep_driver: RTL and testbench

Hardware initiator for the gcd unit. It drives the other side of the gcd operand/result interface.
- Sweeps every operand pair (x,y), x,y in 1..2^SIZE-1, with y as the inner loop.
- Pulses the gcd unit's reset before each pair, presents the operands and waits for data_en.
- Checks data_o against an internal subtractive reference.
- Reports an error count and pass flag, for on-chip self-test of gcd instances.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_ref_sub.sv | 42 ++++
 rtl/gcd_sweep_driver.sv | 184 ++++++++++++++++++
 tb/tb_gcd_sweep_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd unit and its sweep driver.
//   GCD_SIZE      default operand/result width; the gcd unit uses the same constant
//   GCD_TIMEOUT   default per-pair wait budget for the sweep driver
//   sweep_state_e sweep driver FSM state encoding
package gcd_pkg;

    localparam int unsigned GCD_SIZE    = 11;
    localparam int unsigned GCD_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StDrst,
        StWait,
        StCheck,
        StNext,
        StDone
    } sweep_state_e;

endpackage

// File: rtl/gcd_ref_sub.sv
// Iterative subtractive gcd reference: one subtraction per cycle.
//   clk      clock
//   rst      synchronous active-high reset, clears both operands
//   load     captures a_i/b_i as the new operand pair
//   a_i, b_i operands (both nonzero for a meaningful result)
//   ref_done high while the operands are equal, i.e. the result is final
//   ref_gcd  the result, valid while ref_done is high
module gcd_ref_sub
    import gcd_pkg::*;
#(
    parameter int unsigned SIZE = GCD_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    output logic            ref_done,
    output logic [SIZE-1:0] ref_gcd
);

    logic [SIZE-1:0] a_q, b_q;

    // Always larger minus smaller, so neither operand can underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a_i;
            b_q <= b_i;
        end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
        end else if (b_q > a_q) begin
            b_q <= b_q - a_q;
        end
    end

    assign ref_done = (a_q == b_q);
    assign ref_gcd  = a_q;

endmodule

// File: rtl/gcd_sweep_driver.sv
// Self-test initiator for a gcd unit. Sweeps every operand pair (x, y) with
// x, y in 1..2^SIZE-1 (y inner), resets the gcd unit before each pair, waits for
// its result and compares it against a subtractive reference.
//   clk, rst        clock and synchronous active-high reset
//   start           begins a sweep; honoured only when idle or done
//   gcd_rst         reset to the gcd unit (low only while waiting for a result)
//   x_o, y_o        operands to the gcd unit
//   data_i          gcd unit result
//   data_en_i       gcd unit result valid
//   busy            sweep in progress
//   done            sweep finished, held until the next start or rst
//   pass            done with no errors
//   error_cnt       mismatches plus timeouts, saturating
module gcd_sweep_driver
    import gcd_pkg::*;
#(
    parameter int unsigned SIZE       = GCD_SIZE,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned TIMEOUT    = GCD_TIMEOUT,
    parameter int unsigned ERR_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gcd_rst,
    output logic [SIZE-1:0]  x_o,
    output logic [SIZE-1:0]  y_o,
    input  logic [SIZE-1:0]  data_i,
    input  logic             data_en_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_cnt
);

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    localparam logic [SIZE-1:0]  MAX_OP  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    sweep_state_e     state_q, state_d;
    logic [SIZE-1:0]  i_q, i_d;
    logic [SIZE-1:0]  j_q, j_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             got_res_q, got_res_d;
    logic             timeout_q, timeout_d;
    logic [SIZE-1:0]  res_q, res_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             ref_load;
    logic             ref_done;
    logic [SIZE-1:0]  ref_gcd;

    // The reference is loaded on the first DRST cycle, while x_o/y_o already show the pair.
    assign ref_load = (state_q == StDrst) && (rst_cnt_q == '0);

    gcd_ref_sub #(
        .SIZE (SIZE)
    ) u_ref (
        .clk      (clk),
        .rst      (rst),
        .load     (ref_load),
        .a_i      (i_q),
        .b_i      (j_q),
        .ref_done (ref_done),
        .ref_gcd  (ref_gcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            rst_cnt_q <= '0;
            tmo_cnt_q <= '0;
            got_res_q <= 1'b0;
            timeout_q <= 1'b0;
            res_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            rst_cnt_q <= rst_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            got_res_q <= got_res_d;
            timeout_q <= timeout_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        rst_cnt_d = rst_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        got_res_d = got_res_q;
        timeout_d = timeout_q;
        res_d     = res_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StDrst;
                    i_d       = SIZE'(1);
                    j_d       = SIZE'(1);
                    err_d     = '0;
                    rst_cnt_d = '0;
                    tmo_cnt_d = '0;
                    got_res_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end

            StDrst: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = StWait;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end

            StWait: begin
                // Count only until a result arrives; the reference then finishes
                // within 2^SIZE-1 cycles of its load, which TIMEOUT covers.
                if (!got_res_q) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (data_en_i && !got_res_q) begin
                    res_d     = data_i;
                    got_res_d = 1'b1;
                end
                if (got_res_q && ref_done) begin
                    state_d = StCheck;
                end else if (!got_res_q && !data_en_i && (tmo_cnt_q == TW'(TIMEOUT - 1))) begin
                    // A result arriving on the expiry cycle wins over the timeout.
                    timeout_d = 1'b1;
                    state_d   = StCheck;
                end
            end

            StCheck: begin
                if ((timeout_q || (res_q != ref_gcd)) && (err_q != ERR_MAX)) begin
                    err_d = err_q + 1'b1;
                end
                state_d = StNext;
            end

            StNext: begin
                rst_cnt_d = '0;
                tmo_cnt_d = '0;
                got_res_d = 1'b0;
                timeout_d = 1'b0;
                if (j_q != MAX_OP) begin
                    j_d     = j_q + 1'b1;
                    state_d = StDrst;
                end else if (i_q != MAX_OP) begin
                    i_d     = i_q + 1'b1;
                    j_d     = SIZE'(1);
                    state_d = StDrst;
                end else begin
                    state_d = StDone;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign gcd_rst   = (state_q != StWait);
    assign x_o       = i_q;
    assign y_o       = j_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == '0);
    assign error_cnt = err_q;

endmodule

// File: tb/tb_gcd_sweep_driver.sv
module tb_gcd_sweep_driver;

    localparam int unsigned SZ = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          gcd_rst;
    logic [SZ-1:0] x_o, y_o, data_i;
    logic          data_en;
    logic          busy, done, pass;
    logic [7:0]    error_cnt;

    logic          start2;
    logic          gcd_rst2;
    logic [SZ-1:0] x2, y2;
    logic [SZ-1:0] zero_data;
    logic          zero_en;
    logic          busy2, done2, pass2;
    logic [3:0]    err2;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int lat_cnt;

    always #5 clk = ~clk;

    gcd_sweep_driver #(
        .SIZE       (SZ),
        .RST_CYCLES (3),
        .TIMEOUT    (16),
        .ERR_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gcd_rst   (gcd_rst),
        .x_o       (x_o),
        .y_o       (y_o),
        .data_i    (data_i),
        .data_en_i (data_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .error_cnt (error_cnt)
    );

    // Second instance: narrow saturating counter, gcd side dead (data 0, never valid).
    gcd_sweep_driver #(
        .SIZE       (SZ),
        .RST_CYCLES (3),
        .TIMEOUT    (16),
        .ERR_W      (4)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .gcd_rst   (gcd_rst2),
        .x_o       (x2),
        .y_o       (y2),
        .data_i    (zero_data),
        .data_en_i (zero_en),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .error_cnt (err2)
    );

    function automatic int model_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural gcd unit: mode 0 correct, 1 returns 0, 2 wrong on (6,4), 3 never valid.
    always @* begin
        case (mode)
            1:       data_i = '0;
            2:       data_i = (x_o == 3'd6 && y_o == 3'd4) ? 3'd1
                              : SZ'(model_gcd(int'(x_o), int'(y_o)));
            default: data_i = SZ'(model_gcd(int'(x_o), int'(y_o)));
        endcase
    end

    always @(posedge clk) begin
        if (gcd_rst) begin
            lat_cnt <= 0;
            data_en <= 1'b0;
        end else if (lat_cnt >= (int'(x_o) % 4) + 1) begin
            data_en <= (mode != 3);
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one full sweep; logs the operand pair at every WAIT entry.
    task automatic run_sweep(input int m, output int cycles, output int pairs,
                             output int seq_bad, output int fx, output int fy);
        int ei, ej;
        logic prev;
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0; pairs = 0; seq_bad = 0; fx = -1; fy = -1;
        ei = 1; ej = 1;
        prev = gcd_rst;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (prev && !gcd_rst) begin
                pairs++;
                if (int'(x_o) != ei || int'(y_o) != ej) seq_bad++;
                if (ej < 7) ej++;
                else begin
                    ei++;
                    ej = 1;
                end
            end
            prev = gcd_rst;
            if (fx < 0 && error_cnt != 0) begin
                fx = int'(x_o);
                fy = int'(y_o);
            end
        end
    endtask

    typedef struct {
        int mode;
        int exp_err;
        bit exp_pass;
        int exp_cycles;
        int exp_fx;
        int exp_fy;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cyc, pairs, seq_bad, fx, fy, n;
        bit found;

        // mode, errors, pass, cycles (-1 = data dependent), first-error pair
        vecs[0] = '{0, 0,  1'b1, -1,   -1, -1};
        vecs[1] = '{1, 49, 1'b0, -1,   1,  1};
        vecs[2] = '{2, 1,  1'b0, -1,   6,  4};
        vecs[3] = '{3, 49, 1'b0, 1029, 1,  1};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        zero_data = '0; zero_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gcd_rst", gcd_rst, 1);
        check("rst_x", x_o, 0);
        check("rst_y", y_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", error_cnt, 0);
        check("rst_busy2", busy2, 0);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_sweep(vecs[v].mode, cyc, pairs, seq_bad, fx, fy);
            check($sformatf("v%0d_done", v), done, 1);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_gcd_rst", v), gcd_rst, 1);
            check($sformatf("v%0d_err", v), error_cnt, vecs[v].exp_err);
            check($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
            check($sformatf("v%0d_pairs", v), pairs, 49);
            check($sformatf("v%0d_order", v), seq_bad, 0);
            check($sformatf("v%0d_first_err_x", v), fx, vecs[v].exp_fx);
            check($sformatf("v%0d_first_err_y", v), fy, vecs[v].exp_fy);
            if (vecs[v].exp_cycles >= 0)
                check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
        end

        // Reset in the WAIT phase of pair (2,5), with errors already counted.
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            found = (x_o == 3'd2 && y_o == 3'd5 && !gcd_rst);
        end
        check("mid_found_wait_2_5", found, 1);
        check("mid_err_before_rst", error_cnt, 11);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_busy", busy, 0);
        check("mid_gcd_rst", gcd_rst, 1);
        check("mid_err", error_cnt, 0);
        check("mid_x", x_o, 0);
        check("mid_done", done, 0);
        @(negedge clk) begin
            rst = 1'b0;
            start = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_x", x_o, 1);
        check("restart_y", y_o, 1);
        check("restart_busy", busy, 1);
        check("restart_gcd_rst", gcd_rst, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Saturating counter, plus a start pulse mid-sweep that must be ignored.
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (!done2 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            start2 = (n == 100);
            if (n == 101) begin
                check("ign_start_busy", busy2, 1);
                check("ign_start_x", x2, 1);
                check("ign_start_y", y2, 5);
            end
        end
        start2 = 1'b0;
        check("sat_cycles", n, 1029);
        check("sat_done", done2, 1);
        check("sat_err", err2, 15);
        check("sat_pass", pass2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
